vmask_reduce_ctrl: RTL and testbench

VMASK_REDUCE_CTRL -- requirements
Module: vmask_reduce_ctrl

---
 rtl/vmask_reduce_ctrl_pkg.sv | 20 ++
 rtl/vmask_tail_zero.sv | 32 +++
 rtl/vmask_reduce_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vmask_reduce_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmask_reduce_ctrl_pkg.sv
// Shared types and constants for the mask-reduction controller.
// Holds the FSM state encoding, the operation codes and the vfirst "not found" value.
package vmask_reduce_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic OP_FIRST = 1'b0;
  localparam logic OP_POPC  = 1'b1;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Sliced down to DATA_WIDTH by the user; vfirst reports this when no bit is set.
  localparam logic [MAX_DATA_WIDTH-1:0] VFIRST_NONE = '1;

endpackage

// File: rtl/vmask_tail_zero.sv
// Clears mask bits at or above vl on the final word of an instruction.
// A vl that is a multiple of the word width leaves the last word untouched.
module vmask_tail_zero #(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int VL_BITS         = 17
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [VL_BITS-1:0]    vl,
  input  logic                  is_last,
  output logic [DATA_WIDTH-1:0] masked
);

  logic [DATA_WIDTH_BITS-1:0] rem;
  logic [DATA_WIDTH-1:0]      keep;
  logic                       unused_vl_hi;

  assign rem          = vl[DATA_WIDTH_BITS-1:0];
  assign unused_vl_hi = ^vl[VL_BITS-1:DATA_WIDTH_BITS];

  // NOTE: keep gets its default before any conditional write, so no latch is inferred.
  always_comb begin
    keep = '1;
    if (is_last && (rem != '0)) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        keep[i] = (i < int'(rem));
      end
    end
    masked = word & keep;
  end

endmodule

// File: rtl/vmask_reduce_ctrl.sv
// Sequencer for vcpop/vfirst: streams the mask words of one instruction from the
// register file to the reduction datapath and returns the final scalar result.
module vmask_reduce_ctrl
  import vmask_reduce_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int IDX_BITS        = 10,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int VL_BITS         = IDX_BITS + DATA_WIDTH_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_opsel,
  input  logic [VL_BITS-1:0]    cmd_vl,
  input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dp_valid,
  output logic [DATA_WIDTH-1:0] dp_m0,
  output logic [IDX_BITS-1:0]   dp_start_idx,
  output logic                  dp_end,
  output logic [ADDR_WIDTH-1:0] dp_addr,
  output logic                  dp_opsel,
  input  logic                  dp_out_valid,
  input  logic [DATA_WIDTH-1:0] dp_out_vec,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [ADDR_WIDTH-1:0] res_addr
);

  localparam int CNT_BITS = IDX_BITS + 1;
  localparam logic [VL_BITS-1:0]    VL_MAX   = VL_BITS'(1) << (IDX_BITS + DATA_WIDTH_BITS);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = VFIRST_NONE[DATA_WIDTH-1:0];

  state_e                state_q,    state_d;
  logic                  opsel_q,    opsel_d;
  logic [VL_BITS-1:0]    vl_q,       vl_d;
  logic [ADDR_WIDTH-1:0] src_q,      src_d;
  logic [ADDR_WIDTH-1:0] dst_q,      dst_d;
  logic [CNT_BITS-1:0]   nwords_q,   nwords_d;
  logic [CNT_BITS-1:0]   k_q,        k_d;
  logic                  any_set_q,  any_set_d;
  logic                  iss_valid_q, iss_valid_d;
  logic [IDX_BITS-1:0]   iss_idx_q,  iss_idx_d;
  logic                  iss_end_q,  iss_end_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;

  logic [VL_BITS-1:0]    vl_clamped;
  logic [CNT_BITS-1:0]   cmd_nwords;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] masked_word;
  logic                  any_set_now;

  assign vl_clamped = (cmd_vl > VL_MAX) ? VL_MAX : cmd_vl;
  assign cmd_nwords = CNT_BITS'(vl_clamped >> DATA_WIDTH_BITS)
                    + CNT_BITS'(|vl_clamped[DATA_WIDTH_BITS-1:0]);
  assign last_word  = (k_q == (nwords_q - CNT_BITS'(1)));

  // rd_data belongs to the word issued last cycle, so masking follows the issue stage.
  vmask_tail_zero #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_BITS (DATA_WIDTH_BITS),
    .VL_BITS         (VL_BITS)
  ) u_tail_zero (
    .word    (rd_data),
    .vl      (vl_q),
    .is_last (iss_end_q),
    .masked  (masked_word)
  );

  // The word on the datapath this cycle counts immediately, so a result that
  // arrives alongside the last word still sees it.
  assign any_set_now = any_set_q | (iss_valid_q & (|masked_word));

  assign cmd_ready    = (state_q == IDLE) & ~rst;
  assign rd_req       = (state_q == READ);
  assign rd_addr      = rd_req ? (src_q + ADDR_WIDTH'(k_q)) : '0;
  assign dp_valid     = iss_valid_q;
  assign dp_m0        = iss_valid_q ? masked_word : '0;
  assign dp_start_idx = iss_valid_q ? iss_idx_q : '0;
  assign dp_end       = iss_valid_q & iss_end_q;
  assign dp_addr      = iss_valid_q ? dst_q : '0;
  assign dp_opsel     = iss_valid_q & opsel_q;
  assign res_valid    = (state_q == RESP);
  assign res_data     = res_data_q;
  assign res_addr     = res_addr_q;

  always_comb begin
    state_d     = state_q;
    opsel_d     = opsel_q;
    vl_d        = vl_q;
    src_d       = src_q;
    dst_d       = dst_q;
    nwords_d    = nwords_q;
    k_d         = k_q;
    any_set_d   = any_set_now;
    iss_valid_d = 1'b0;
    iss_idx_d   = '0;
    iss_end_d   = 1'b0;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opsel_d   = cmd_opsel;
          vl_d      = vl_clamped;
          src_d     = cmd_src_addr;
          dst_d     = cmd_dst_addr;
          nwords_d  = cmd_nwords;
          k_d       = '0;
          any_set_d = 1'b0;
          if (cmd_nwords == '0) begin
            res_data_d = (cmd_opsel == OP_POPC) ? '0 : ALL_ONES;
            res_addr_d = cmd_dst_addr;
            state_d    = RESP;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        iss_valid_d = 1'b1;
        iss_idx_d   = k_q[IDX_BITS-1:0];
        iss_end_d   = last_word;
        if (last_word) begin
          state_d = WAIT;
        end else begin
          k_d = k_q + CNT_BITS'(1);
        end
      end
      WAIT: begin
        if (dp_out_valid) begin
          res_data_d = ((opsel_q == OP_POPC) || any_set_now) ? dp_out_vec : ALL_ONES;
          res_addr_d = dst_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset that clears every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opsel_q     <= 1'b0;
      vl_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      nwords_q    <= '0;
      k_q         <= '0;
      any_set_q   <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      iss_end_q   <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      opsel_q     <= opsel_d;
      vl_q        <= vl_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      nwords_q    <= nwords_d;
      k_q         <= k_d;
      any_set_q   <= any_set_d;
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      iss_end_q   <= iss_end_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
    end
  end

endmodule

// File: tb/tb_vmask_reduce_ctrl.sv
// Scoreboard bench for vmask_reduce_ctrl with a register-file responder and a
// simple reduction-datapath model; expected results come from the stimulus.
module tb_vmask_reduce_ctrl;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IB = 10;
  localparam int VB = 17;

  typedef struct {
    logic [63:0] m0;
    int          idx;
    bit          last;
    logic [31:0] addr;
    bit          op;
  } dp_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_opsel = 1'b0;
  logic [VB-1:0] cmd_vl = '0;
  logic [AW-1:0] cmd_src_addr = '0;
  logic [AW-1:0] cmd_dst_addr = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          dp_valid;
  logic [DW-1:0] dp_m0;
  logic [IB-1:0] dp_start_idx;
  logic          dp_end;
  logic [AW-1:0] dp_addr;
  logic          dp_opsel;
  logic          dp_out_valid = 1'b0;
  logic [DW-1:0] dp_out_vec = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_addr;

  logic [63:0] mem [0:1023];
  logic [31:0] exp_rd_q  [$];
  dp_exp_t     exp_dp_q  [$];
  logic [63:0] exp_res_q [$];
  logic [31:0] exp_addr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit spur = 1'b0;

  always #5 clk = ~clk;

  vmask_reduce_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opsel(cmd_opsel),
    .cmd_vl(cmd_vl), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_valid(dp_valid), .dp_m0(dp_m0), .dp_start_idx(dp_start_idx),
    .dp_end(dp_end), .dp_addr(dp_addr), .dp_opsel(dp_opsel),
    .dp_out_valid(dp_out_valid), .dp_out_vec(dp_out_vec),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_addr(res_addr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Register file: data for a strobe arrives the next cycle; junk otherwise.
  always @(posedge clk) begin
    rd_data <= rd_req ? mem[rd_addr[9:0]] : {$urandom, $urandom};
  end

  // Datapath model: {found, acc} folded word by word.
  function automatic logic [64:0] dpm_step(input logic [64:0] st, input logic [63:0] w,
                                           input int idx, input bit op);
    logic [64:0] r;
    r = (idx == 0) ? 65'd0 : st;
    if (op) begin
      r[63:0] = r[63:0] + 64'($countones(w));
    end else if (!r[64]) begin
      for (int b = 63; b >= 0; b--) begin
        if (w[b]) r = {1'b1, 64'(idx * 64 + b)};
      end
    end
    return r;
  endfunction

  logic [64:0] dpm_st = '0;
  logic [63:0] dpm_res = '0;
  int          dpm_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      dp_out_valid <= 1'b0;
      dp_out_vec   <= '0;
      dpm_st       <= '0;
      dpm_cnt      <= 0;
    end else begin
      dp_out_valid <= spur;
      dp_out_vec   <= spur ? 64'hDEAD_BEEF_0BAD_F00D : 64'h0;
      if (dpm_cnt == 1) begin
        dp_out_valid <= 1'b1;
        dp_out_vec   <= dpm_res;
      end
      if (dpm_cnt > 0) dpm_cnt <= dpm_cnt - 1;
      if (dp_valid) begin
        dpm_st <= dpm_step(dpm_st, dp_m0, int'(dp_start_idx), dp_opsel);
        if (dp_end) begin
          dpm_res <= dpm_step(dpm_st, dp_m0, int'(dp_start_idx), dp_opsel) & 65'h0_FFFF_FFFF_FFFF_FFFF;
          dpm_cnt <= 2;
        end
      end
    end
  end

  dp_exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(rd_req), 64'd0);
        else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
      end
      if (dp_valid) begin
        if (exp_dp_q.size() == 0) begin
          check("dp_unexpected", 64'(dp_valid), 64'd0);
        end else begin
          mon_e = exp_dp_q.pop_front();
          check("dp_m0", dp_m0, mon_e.m0);
          check("dp_start_idx", 64'(dp_start_idx), 64'(mon_e.idx));
          check("dp_end", 64'(dp_end), 64'(mon_e.last));
          check("dp_addr", 64'(dp_addr), 64'(mon_e.addr));
          check("dp_opsel", 64'(dp_opsel), 64'(mon_e.op));
        end
      end else begin
        check("dp_idle_zero", dp_m0 | 64'(dp_start_idx) | 64'(dp_end) | 64'(dp_addr)
              | 64'(dp_opsel), 64'd0);
      end
    end
  end

  function automatic logic [63:0] ref_result(input bit op, input int vl, input int src);
    logic [63:0] cnt;
    cnt = 0;
    for (int e = 0; e < vl; e++) begin
      if (mem[(src + e / 64) % 1024][e % 64]) begin
        if (op) cnt++;
        else return 64'(e);
      end
    end
    return op ? cnt : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic push_expect(input bit op, input int vl, input int src, input int dst);
    int nw, rem;
    logic [63:0] w;
    nw  = (vl + 63) / 64;
    rem = vl % 64;
    for (int k = 0; k < nw; k++) begin
      exp_rd_q.push_back(32'(src + k));
      w = mem[(src + k) % 1024];
      if (k == nw - 1 && rem != 0) w = w & ((64'd1 << rem) - 64'd1);
      exp_dp_q.push_back('{m0: w, idx: k, last: (k == nw - 1), addr: 32'(dst), op: op});
    end
  endtask

  task automatic drive_cmd(input bit op, input int vl, input int src, input int dst);
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid    = 1'b1;
    cmd_opsel    = op;
    cmd_vl       = VB'(vl);
    cmd_src_addr = 32'(src);
    cmd_dst_addr = 32'(dst);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input bit op, input int vl, input int src, input int dst, input int hold);
    logic [63:0] exp_r;
    logic [31:0] exp_a;
    bit got;
    push_expect(op, vl, src, dst);
    exp_res_q.push_back(ref_result(op, vl, src));
    exp_addr_q.push_back(32'(dst));
    drive_cmd(op, vl, src, dst);
    // First negedge after accept.
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (vl == 0) begin
      check("vl0_no_rd", 64'(rd_req), 64'd0);
      check("vl0_res_valid", 64'(res_valid), 64'd1);
    end else begin
      check("first_rd_req", 64'(rd_req), 64'd1);
      check("dp_not_yet", 64'(dp_valid), 64'd0);
      @(negedge clk);
      check("first_dp_latency", 64'(dp_valid), 64'd1);
    end
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp_r = exp_res_q.pop_front();
    exp_a = exp_addr_q.pop_front();
    if (!got) begin
      check("res_timeout", 64'(res_valid), 64'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      spur = (h == 1);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_data", res_data, exp_r);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    spur = 1'b0;
    res_ready = 1'b1;
    check("res_data", res_data, exp_r);
    check("res_addr", 64'(res_addr), 64'(exp_a));
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("post_res_valid", 64'(res_valid), 64'd0);
    check("post_cmd_ready", 64'(cmd_ready), 64'd1);
    check("dp_queue_drained", 64'(exp_dp_q.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_dp_valid", 64'(dp_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_addr", 64'(res_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // vcpop, single full word.
    mem[16'h10] = 64'hFF;
    run_cmd(1'b1, 64, 'h10, 'h100, 0);

    // vfirst across three words, last one partial.
    mem['h20] = 64'h0; mem['h21] = 64'h0; mem['h22] = 64'h3;
    run_cmd(1'b0, 130, 'h20, 'h200, 0);

    // vfirst whose only set bit lies beyond vl.
    mem['h30] = 64'h0; mem['h31] = 64'd1 << 40;
    run_cmd(1'b0, 100, 'h30, 'h300, 0);

    // vl = 0 for both operations.
    run_cmd(1'b1, 0, 'h40, 'h400, 0);
    run_cmd(1'b0, 0, 'h40, 'h404, 0);

    // Back-pressure with a stray datapath result while in RESP.
    for (int i = 0; i < 4; i++) mem['h50 + i] = {$urandom, $urandom};
    run_cmd(1'b1, 200, 'h50, 'h500, 5);

    // vfirst with the only set bit in a one-element last word.
    for (int i = 0; i < 5; i++) mem['h60 + i] = '0;
    mem['h64] = 64'h1;
    run_cmd(1'b0, 257, 'h60, 'h600, 2);

    // Random vcpop over several words.
    for (int i = 0; i < 5; i++) mem['h70 + i] = {$urandom, $urandom};
    run_cmd(1'b1, 300, 'h70, 'h700, 1);

    // Reset in the middle of READ after two words.
    for (int i = 0; i < 4; i++) mem['h80 + i] = {$urandom, $urandom};
    push_expect(1'b1, 256, 'h80, 'h800);
    drive_cmd(1'b1, 256, 'h80, 'h800);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_rd_q.delete();
    exp_dp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_res_valid", 64'(res_valid), 64'd0);
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    end
    mem['h90] = 64'hF;
    run_cmd(1'b1, 64, 'h90, 'h900, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
